// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: round-robin interrupt controller between external sources
// and the miriscv trap logic. A scan pointer walks the masked request vector
// one source per cycle; the first hit is held through PEND (waiting for the
// trap to be taken) and SERV (handler running), and is retired in FIN with a
// one-cycle completion pulse. The scan resumes after the serviced source.
module miriscv_irq_ctrl #(
    parameter int unsigned N_SRC   = 32,
    parameter logic [31:0] CAUSE_B = 32'h8000_0010
) (
    input  logic             clk_i,
    input  logic             rst_n_i,     // active-high synchronous reset
    input  logic [N_SRC-1:0] int_req_i,
    input  logic [N_SRC-1:0] mie_i,
    input  logic             int_ack_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_SRC-1:0] int_fin_o
);

    localparam int unsigned      IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_SRC - 1);
    localparam logic [N_SRC-1:0] FIN_LSB = N_SRC'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic             hit;
    logic             held;
    logic [IDX_W-1:0] cnt_inc;
    logic [IDX_W-1:0] idx_inc;

    // Scan hit, held-source check and wrapping successors of cnt/idx
    always_comb begin
        hit     = int_req_i[cnt] & mie_i[cnt];
        held    = int_req_i[idx] & mie_i[idx];
        cnt_inc = (cnt == IDX_MAX) ? '0 : cnt + IDX_W'(1);
        idx_inc = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end

    // Controller FSM with registered int_o, mcause_o and int_fin_o
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            int_o     <= 1'b0;
            mcause_o  <= '0;
            int_fin_o <= '0;
        end else begin
            // int_fin_o is only ever high for the single FIN cycle
            int_fin_o <= '0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        idx      <= cnt;
                        mcause_o <= CAUSE_B + 32'(cnt);
                        int_o    <= 1'b1;
                        state    <= PEND;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PEND: begin
                    // Ack is checked first so a same-cycle request drop still
                    // lets the already-taken trap proceed to service.
                    if (int_ack_i) begin
                        int_o <= 1'b0;
                        state <= SERV;
                    end else if (!held) begin
                        int_o <= 1'b0;
                        cnt   <= idx_inc;
                        state <= IDLE;
                    end
                end
                SERV: begin
                    if (int_rst_i) begin
                        int_fin_o <= FIN_LSB << idx;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    cnt   <= idx_inc;
                    state <= IDLE;
                end
                default: begin
                    int_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
